// File: rtl/exception_sequencer.sv
// Exception entry sequencer: captures the cause, saves EPC, reads the handler byte at the vector, loads PC.
// Capture edge to pc_wr takes 2 + MEM_LAT cycles; busy stays high for 3 + MEM_LAT cycles while flags are ignored.
module exception_sequencer #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_invalid_op,
    input  logic        exc_overflow,
    input  logic        exc_div_zero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_rd_data,
    output logic [1:0]  Exception_Control,
    output logic        mem_addr_sel,
    output logic        epc_wr,
    output logic [31:0] epc_out,
    output logic        pc_wr,
    output logic [31:0] pc_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SAVE_EPC = 3'd1,
        READ_VEC = 3'd2,
        LOAD_PC  = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        any_flag;
    logic [1:0]  flag_code;
    logic        unused_rd_hi;

    // Only the handler byte matters; the rest of the read word is discarded.
    assign unused_rd_hi = ^mem_rd_data[31:8];

    assign any_flag = exc_invalid_op | exc_overflow | exc_div_zero;

    always_comb begin
        flag_code = 2'b10;
        if (exc_invalid_op)
            flag_code = 2'b00;
        else if (exc_overflow)
            flag_code = 2'b01;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cause_q <= 2'b00;
            epc_q   <= 32'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        epc_d   = epc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_flag) begin
                    state_d = SAVE_EPC;
                    cause_d = flag_code;
                end
            end
            SAVE_EPC: begin
                // pc_in already points past the faulting instruction.
                epc_d   = pc_in - 32'd4;
                cnt_d   = CNT_INIT;
                state_d = READ_VEC;
            end
            READ_VEC: begin
                if (cnt_q == 3'd0)
                    state_d = LOAD_PC;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            LOAD_PC: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Exception_Control = cause_q;
        epc_out           = epc_q;
        epc_wr            = (state_q == SAVE_EPC);
        mem_addr_sel      = (state_q == READ_VEC) || (state_q == LOAD_PC);
        pc_wr             = (state_q == LOAD_PC);
        pc_data           = 32'd0;
        if (state_q == LOAD_PC)
            pc_data = {24'd0, mem_rd_data[7:0]};
        busy              = (state_q != IDLE);
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Drives two sequencers (MEM_LAT 1 and 3) with directed then random flags against a cycle-count schedule model.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        f_inv, f_ov, f_dz;
    logic [31:0] pc_in;
    logic [23:0] upper;
    logic [7:0]  vmem [256];

    logic [1:0]  ec_o  [2];
    logic        sel_o [2];
    logic        ew_o  [2];
    logic [31:0] epc_o [2];
    logic        pw_o  [2];
    logic [31:0] pd_o  [2];
    logic        busy_o[2];
    logic [31:0] mrd0, mrd1;
    logic [7:0]  a0, a1;

    // Memory model: vector address is 253 + selector; upper read bits are junk.
    assign a0   = 8'd253 + {6'd0, ec_o[0]};
    assign a1   = 8'd253 + {6'd0, ec_o[1]};
    assign mrd0 = sel_o[0] ? {upper, vmem[a0]} : 32'h5A5A5A5A;
    assign mrd1 = sel_o[1] ? {upper, vmem[a1]} : 32'hA5A5A5A5;

    exception_sequencer #(.MEM_LAT(1)) dut0 (
        .clk(clk), .reset(reset),
        .exc_invalid_op(f_inv), .exc_overflow(f_ov), .exc_div_zero(f_dz),
        .pc_in(pc_in), .mem_rd_data(mrd0),
        .Exception_Control(ec_o[0]), .mem_addr_sel(sel_o[0]), .epc_wr(ew_o[0]),
        .epc_out(epc_o[0]), .pc_wr(pw_o[0]), .pc_data(pd_o[0]), .busy(busy_o[0])
    );

    exception_sequencer #(.MEM_LAT(3)) dut1 (
        .clk(clk), .reset(reset),
        .exc_invalid_op(f_inv), .exc_overflow(f_ov), .exc_div_zero(f_dz),
        .pc_in(pc_in), .mem_rd_data(mrd1),
        .Exception_Control(ec_o[1]), .mem_addr_sel(sel_o[1]), .epc_wr(ew_o[1]),
        .epc_out(epc_o[1]), .pc_wr(pw_o[1]), .pc_data(pd_o[1]), .busy(busy_o[1])
    );

    int          vectors = 0;
    int          miscompares = 0;
    // k = cycles elapsed since the capture edge, 0 when idle.
    int          k   [2];
    int          lat [2];
    logic [1:0]  m_ec [2];
    logic [31:0] m_epc[2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    task automatic tick();
        logic [7:0] va;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                k[d] = 0; m_ec[d] = 2'b00; m_epc[d] = 32'd0;
            end else if (k[d] == 0) begin
                if (f_inv | f_ov | f_dz) begin
                    m_ec[d] = f_inv ? 2'b00 : (f_ov ? 2'b01 : 2'b10);
                    k[d] = 1;
                end
            end else begin
                if (k[d] == 1)
                    m_epc[d] = pc_in - 32'd4;
                k[d] = (k[d] == lat[d] + 3) ? 0 : k[d] + 1;
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            va = 8'd253 + {6'd0, m_ec[d]};
            chk("busy", d, {31'd0, busy_o[d]}, {31'd0, (k[d] != 0)});
            chk("epc_wr", d, {31'd0, ew_o[d]}, {31'd0, (k[d] == 1)});
            chk("mem_addr_sel", d, {31'd0, sel_o[d]}, {31'd0, (k[d] >= 2 && k[d] <= lat[d] + 2)});
            chk("pc_wr", d, {31'd0, pw_o[d]}, {31'd0, (k[d] == lat[d] + 2)});
            chk("exc_ctrl", d, {30'd0, ec_o[d]}, {30'd0, m_ec[d]});
            chk("epc_out", d, epc_o[d], m_epc[d]);
            if (k[d] == lat[d] + 2)
                chk("pc_data", d, pd_o[d], {24'd0, vmem[va]});
            else if (reset)
                chk("pc_data_rst", d, pd_o[d], 32'd0);
        end
    endtask

    task automatic flags_off();
        f_inv = 1'b0; f_ov = 1'b0; f_dz = 1'b0;
    endtask

    initial begin
        lat[0] = 1; lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            k[d] = 0; m_ec[d] = 2'b00; m_epc[d] = 32'd0;
        end
        for (int i = 0; i < 256; i++)
            vmem[i] = 8'($urandom);
        reset = 1'b1; flags_off(); pc_in = 32'd0; upper = 24'd0;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Overflow at pc 0x40, handler byte 0x9C.
        vmem[254] = 8'h9C; pc_in = 32'h40; f_ov = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // All flags at once: invalid_op wins.
        pc_in = 32'h1234; f_inv = 1'b1; f_ov = 1'b1; f_dz = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // Div-zero with junk upper read bits.
        vmem[255] = 8'hFF; upper = 24'hABCDEF; pc_in = 32'h200; f_dz = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // EPC wraps below zero.
        pc_in = 32'h0; f_inv = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // Reset while reading the vector, then a fresh sequence.
        pc_in = 32'h80; f_ov = 1'b1;
        tick(); flags_off();
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        pc_in = 32'h90; f_dz = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // Overflow pulse while dut0 sits in LOAD_PC is ignored.
        pc_in = 32'h100; f_dz = 1'b1;
        tick(); flags_off();
        tick(); tick();
        f_ov = 1'b1;
        tick(); flags_off();
        repeat (8) tick();

        // Flag held high re-triggers back to back.
        pc_in = 32'h300; f_ov = 1'b1;
        repeat (14) tick();
        flags_off();
        repeat (8) tick();

        repeat (400) begin
            reset = ($urandom_range(0, 49) == 0);
            f_inv = ($urandom_range(0, 7) == 0);
            f_ov  = ($urandom_range(0, 7) == 0);
            f_dz  = ($urandom_range(0, 7) == 0);
            pc_in = $urandom;
            upper = 24'($urandom);
            if ($urandom_range(0, 9) == 0)
                vmem[8'd253 + 8'($urandom_range(0, 2))] = 8'($urandom);
            tick();
        end
        reset = 1'b0; flags_off();
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
